core_run_ctrl: RTL
==================

# core_run_ctrl

Run-control sequencer for the accumulator core. It loads a program into instruction memory through a valid/ready stream, holds the core in reset until the program is loaded, and then gates core execution with run, single-step, pause and stop commands. It detects HALT and counts executed cycles. It sits between the host/debug port and the core: `CoreEn` is ANDed into the instruction controller's load enables, and `CoreRst` drives the core's reset.

## Interface
- `IMEM_AW`, 8: instruction-memory address width (depth = 2^IMEM_AW).
- `INSTR_W`, 8: instruction width; bits [INSTR_W-1:INSTR_W-4] are the opcode.
- `CYC_W`, 16: cycle-counter width.
- `WDOG_LIMIT`, 16'hFFF0: watchdog trip count; used only with the watchdog compiled in.
- `Clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `LdValid`  in  1  host program word valid.
- `LdData`  in  INSTR_W  program word.
- `LdLast`  in  1  marks the final word.
- `LdReady`  out  1  block accepts a word.
- `ImemWe`  out  1  instruction-memory write strobe.
- `ImemAddr`  out  IMEM_AW  write address.
- `ImemWdata`  out  INSTR_W  write data.
- `Run`, `Step`, `Stop`  in  1 each  command pulses.
- `Opcode`  in  4  current IR opcode.
- `CoreEn`  out  1  core may update IR/PC/Reg/Acc.
- `CoreRst`  out  1  holds the core (PC=0, IR cleared).
- `Done`  out  1  core halted.
- `LoadErr`  out  1  sticky load overflow.
- `WdogTrip`  out  1  sticky watchdog trip.
- `Status`  out  3  current state encoding.
- `CycleCount`  out  CYC_W  core-enabled cycles since the last PRIME.

## Operation
- States: IDLE, LOAD, PRIME, PAUSE, RUN, STEP, HALTED.
- Outputs are Moore decodes of the state unless noted otherwise.
- Word handshake: a word is accepted on a rising edge when `LdValid && LdReady`.
- IDLE
  - `LdReady=1`, `CoreRst=1`, `CoreEn=0`.
  - An accepted word moves the block to LOAD. That word goes to address 0 and clears `LoadErr`.
  - `Run` moves the block to PRIME, reusing the resident program.
- LOAD
  - `LdReady=1`, `CoreRst=1`.
  - Each accepted word goes to the next address.
  - Accepting a word with `LdLast` moves the block to PRIME.
  - Accepting a word at address 2^IMEM_AW-1 without `LdLast` writes it, sets `LoadErr`, and moves the block to PRIME.
- PRIME
  - Lasts one cycle: `CoreRst=1`, `CycleCount` cleared, `LdReady=0`.
  - Always moves to PAUSE.
- PAUSE
  - `CoreEn=0`, `CoreRst=0`.
  - `Run` moves to RUN; `Step` moves to STEP; `Stop` moves to IDLE.
- RUN
  - `CoreEn=1`; `CycleCount` increments each cycle and saturates at all-ones.
  - `Opcode==4'b1111` moves to HALTED.
  - `Stop` moves to PAUSE.
- STEP
  - Exactly one cycle with `CoreEn=1`; `CycleCount` increments.
  - Then moves to PAUSE, or to HALTED if `Opcode` is HALT.
- HALTED
  - `Done=1`, `CoreEn=0`.
  - `Run` moves to PRIME; an accepted word moves to LOAD (restarting at address 0); `Stop` moves to IDLE.
- Command priority: `Stop` > `Run` > `Step`. Commands not listed for a state are ignored. HALT detection beats `Stop` in RUN.
- `LdReady=0` in every state except IDLE, LOAD and HALTED. `LdValid` is ignored in those states.

## Timing
- Reset values:
  - State IDLE, `Status=0`.
  - `LdReady=1`, `CoreRst=1`.
  - `CoreEn=0`, `ImemWe=0`, `ImemAddr=0`, `ImemWdata=0`.
  - `Done=0`, `LoadErr=0`, `WdogTrip=0`, `CycleCount=0`.
- Memory write latency is one cycle: a word accepted at edge n gives `ImemWe=1` with registered address and data during cycle n+1.
- Back-to-back accepts give one write per cycle.
- A command sampled at edge n takes effect on outputs from cycle n+1.
- After `LdLast` is accepted at edge n:
  - PRIME at n+1.
  - PAUSE at n+2.
  - Earliest `CoreEn=1` at n+3 (given `Run` at edge n+2).
- A HALT opcode sampled in RUN at edge n gives `CoreEn=0` and `Done=1` from cycle n+1.
- `reset` mid-operation aborts the load or run immediately. The partial program is left in memory.

## Configuration
- `CORE_RUN_CTRL_WATCHDOG_EN` defined:
  - In RUN, `CycleCount==WDOG_LIMIT` forces HALTED on the next edge and sets `WdogTrip`.
  - `WdogTrip` stays set until the next PRIME or reset.
- Not defined: `WdogTrip` is tied to 0, `WDOG_LIMIT` is unused, and RUN is unbounded.

## Structure
- Package `core_run_ctrl_pkg` holds:
  - the state enum and its `Status` encoding;
  - `OPC_HALT=4'b1111`;
  - the opcode field position helpers.
- Sub-module `imem_loader` holds the handshake, the address counter, the overflow/`LoadErr` logic and the registered write outputs. It is driven by a load-enable and an address-clear from the FSM.

## Test plan
- Load 3 words 0x41, 0x12, 0xFF (last) from IDLE: writes at addresses 0, 1, 2 one cycle after each accept; then PRIME, then PAUSE; `LoadErr=0`.
- Overflow with IMEM_AW=2: send 5 words, none marked last. The 4th word is written at address 3, `LoadErr=1`, the state goes to PRIME, and the 5th word is not accepted.
- From PAUSE, assert `Step` 3 times with `Opcode=0001`: exactly 3 single `CoreEn` cycles and `CycleCount=3`.
- From PAUSE, `Run`, then `Opcode=1111` after 10 cycles: `CycleCount=10`, `Done=1`, `CoreEn=0` next cycle.
- In RUN, assert `Stop` and `Run` together: the state goes to PAUSE. Assert `reset` during LOAD: all reset values return within the same cycle.
- With `CORE_RUN_CTRL_WATCHDOG_EN` and WDOG_LIMIT=5, run with no HALT: HALTED after 5 counted cycles, `WdogTrip=1`.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_pkg
//
// Shared definitions for the run-control sequencer of the accumulator core.
//
// Contents:
//   runState_e  - sequencer states; the enum value is also the Status code
//                 driven to the host (IDLE=0 ... HALTED=6).
//   OPC_HALT    - opcode that stops the core.
//   OPC_W       - width of the opcode field at the top of an instruction.
//   opcodeMsb / opcodeLsb - bit positions of the opcode field inside an
//                 instruction word of a given width.
//   isHalt      - true when an opcode is the HALT opcode.
// ---------------------------------------------------------------------------
package core_run_ctrl_pkg;

    // Sequencer states. The numeric value is visible on Status, so the
    // ordering here is part of the host-facing interface.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRIME  = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5,
        ST_HALTED = 3'd6
    } runState_e;

    localparam int         OPC_W    = 4;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    // The opcode occupies the top OPC_W bits of an instruction word.
    function automatic int opcodeMsb(input int instrW);
        return instrW - 1;
    endfunction

    function automatic int opcodeLsb(input int instrW);
        return instrW - OPC_W;
    endfunction

    function automatic logic isHalt(input logic [3:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/core_run_ctrl_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Program-load datapath of the run-control sequencer. Accepts program words
// from the host over a valid/ready stream and turns each accepted word into a
// registered instruction-memory write one cycle later.
//
// Ports:
//   Clk, reset   - clock and asynchronous active-high reset.
//   loadEn       - from the FSM: the block may accept words (drives LdReady).
//   addrClear    - from the FSM: the next accepted word starts a new program
//                  at address 0 and clears LoadErr.
//   LdValid      - host word valid.
//   LdData       - host program word.
//   LdLast       - host marks the final word of the program.
//   LdReady      - handshake ready back to the host.
//   wordAccept   - a word is accepted on the coming edge.
//   loadDone     - the word accepted on the coming edge ends the program,
//                  either through LdLast or by filling the last address.
//   ImemWe       - registered instruction-memory write strobe.
//   ImemAddr     - registered write address.
//   ImemWdata    - registered write data.
//   LoadErr      - sticky flag: the program did not fit in the memory.
// ---------------------------------------------------------------------------
module imem_loader
    import core_run_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int INSTR_W = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               loadEn,
    input  logic               addrClear,
    input  logic               LdValid,
    input  logic [INSTR_W-1:0] LdData,
    input  logic               LdLast,
    output logic               LdReady,
    output logic               wordAccept,
    output logic               loadDone,
    output logic               ImemWe,
    output logic [IMEM_AW-1:0] ImemAddr,
    output logic [INSTR_W-1:0] ImemWdata,
    output logic               LoadErr
);

    localparam logic [IMEM_AW-1:0] LAST_ADDR = '1;

    logic [IMEM_AW-1:0] nextAddr;
    logic [IMEM_AW-1:0] writeAddr;
    logic               overflow;

    // Handshake and address selection. A fresh program always lands at
    // address 0; otherwise words follow on from the previous one. A word
    // written to the last address without LdLast means the program was
    // truncated, which ends the load and raises the overflow flag.
    assign LdReady    = loadEn;
    assign wordAccept = LdValid && loadEn;
    assign writeAddr  = addrClear ? '0 : nextAddr;
    assign overflow   = wordAccept && (writeAddr == LAST_ADDR) && !LdLast;
    assign loadDone   = wordAccept && (LdLast || (writeAddr == LAST_ADDR));

    // Address counter: remembers where the next word of the current program
    // goes.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            nextAddr <= '0;
        end else if (wordAccept) begin
            nextAddr <= writeAddr + 1'b1;
        end
    end

    // Registered write port: each accepted word appears on the memory
    // interface during the following cycle, so back-to-back accepts give one
    // write per cycle. Address and data hold their last value between writes.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ImemWe    <= 1'b0;
            ImemAddr  <= '0;
            ImemWdata <= '0;
        end else begin
            ImemWe <= wordAccept;
            if (wordAccept) begin
                ImemAddr  <= writeAddr;
                ImemWdata <= LdData;
            end
        end
    end

    // Sticky load-overflow flag: the first word of a new program clears it
    // (unless that very word already overflows), and any truncating word
    // sets it.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            LoadErr <= 1'b0;
        end else if (wordAccept && addrClear) begin
            LoadErr <= overflow;
        end else if (overflow) begin
            LoadErr <= 1'b1;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
//
// Run-control sequencer for the accumulator core. Loads a program into the
// instruction memory, keeps the core in reset until a program is resident,
// then gates core execution with run / single-step / pause / stop commands,
// detects HALT and counts core-enabled cycles.
//
// Optional feature: define CORE_RUN_CTRL_WATCHDOG_EN to compile in a
// watchdog that forces HALTED once CycleCount reaches WDOG_LIMIT in RUN and
// raises the sticky WdogTrip flag. Without it WdogTrip is constant 0 and RUN
// is unbounded.
//
// Parameters:
//   IMEM_AW     - instruction-memory address width (depth 2^IMEM_AW).
//   INSTR_W     - instruction width; the opcode is the top four bits.
//   CYC_W       - cycle-counter width.
//   WDOG_LIMIT  - watchdog trip count (watchdog build only).
//
// Ports:
//   Clk, reset           - clock and asynchronous active-high reset.
//   LdValid/LdData/LdLast/LdReady - program-word stream from the host.
//   ImemWe/ImemAddr/ImemWdata     - instruction-memory write port.
//   Run, Step, Stop      - host command pulses (Stop > Run > Step).
//   Opcode               - opcode of the core's current instruction.
//   CoreEn               - core may update IR/PC/Reg/Acc this cycle.
//   CoreRst              - holds the core in reset.
//   Done                 - core has halted.
//   LoadErr              - sticky: last program overflowed the memory.
//   WdogTrip             - sticky: watchdog stopped the core.
//   Status               - current state code (see runState_e).
//   CycleCount           - core-enabled cycles since the last PRIME,
//                          saturating at all-ones.
// ---------------------------------------------------------------------------
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int               IMEM_AW    = 8,
    parameter int               INSTR_W    = 8,
    parameter int               CYC_W      = 16,
    parameter logic [CYC_W-1:0] WDOG_LIMIT = CYC_W'(16'hFFF0)
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               LdValid,
    input  logic [INSTR_W-1:0] LdData,
    input  logic               LdLast,
    output logic               LdReady,
    output logic               ImemWe,
    output logic [IMEM_AW-1:0] ImemAddr,
    output logic [INSTR_W-1:0] ImemWdata,
    input  logic               Run,
    input  logic               Step,
    input  logic               Stop,
    input  logic [3:0]         Opcode,
    output logic               CoreEn,
    output logic               CoreRst,
    output logic               Done,
    output logic               LoadErr,
    output logic               WdogTrip,
    output logic [2:0]         Status,
    output logic [CYC_W-1:0]   CycleCount
);

    runState_e state;
    runState_e nextState;

    logic loadEn;
    logic addrClear;
    logic wordAccept;
    logic loadDone;
    logic wdogHit;

    // Program loader: handshake, address counter, overflow flag and the
    // registered memory write port.
    imem_loader #(
        .IMEM_AW (IMEM_AW),
        .INSTR_W (INSTR_W)
    ) loader (
        .Clk        (Clk),
        .reset      (reset),
        .loadEn     (loadEn),
        .addrClear  (addrClear),
        .LdValid    (LdValid),
        .LdData     (LdData),
        .LdLast     (LdLast),
        .LdReady    (LdReady),
        .wordAccept (wordAccept),
        .loadDone   (loadDone),
        .ImemWe     (ImemWe),
        .ImemAddr   (ImemAddr),
        .ImemWdata  (ImemWdata),
        .LoadErr    (LoadErr)
    );

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    // Watchdog: once the core has been running for WDOG_LIMIT counted
    // cycles, the next edge stops it regardless of opcode or commands.
    assign wdogHit = (state == ST_RUN) && (CycleCount == WDOG_LIMIT);

    // Sticky trip flag, cleared only when a new run is primed.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            WdogTrip <= 1'b0;
        end else if (state == ST_PRIME) begin
            WdogTrip <= 1'b0;
        end else if (wdogHit) begin
            WdogTrip <= 1'b1;
        end
    end
`else
    logic unusedWdogLimit;

    assign wdogHit         = 1'b0;
    assign WdogTrip        = 1'b0;
    assign unusedWdogLimit = ^WDOG_LIMIT;
`endif

    // State register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and Moore output decode. In the states that accept
    // program words, an accepted word outranks any command: the handshake
    // already commits the word to memory, so the sequencer must follow it
    // into a load. A first word that is also the last word goes straight to
    // PRIME. In RUN, stopping because of HALT or the watchdog outranks Stop.
    always_comb begin
        nextState = state;
        loadEn    = 1'b0;
        addrClear = 1'b0;
        CoreEn    = 1'b0;
        CoreRst   = 1'b0;
        Done      = 1'b0;

        case (state)
            ST_IDLE: begin
                loadEn    = 1'b1;
                addrClear = 1'b1;
                CoreRst   = 1'b1;
                if (wordAccept) begin
                    nextState = loadDone ? ST_PRIME : ST_LOAD;
                end else if (Run) begin
                    nextState = ST_PRIME;
                end
            end

            ST_LOAD: begin
                loadEn  = 1'b1;
                CoreRst = 1'b1;
                if (loadDone) begin
                    nextState = ST_PRIME;
                end
            end

            ST_PRIME: begin
                CoreRst   = 1'b1;
                nextState = ST_PAUSE;
            end

            ST_PAUSE: begin
                if (Stop) begin
                    nextState = ST_IDLE;
                end else if (Run) begin
                    nextState = ST_RUN;
                end else if (Step) begin
                    nextState = ST_STEP;
                end
            end

            ST_RUN: begin
                CoreEn = 1'b1;
                if (wdogHit || isHalt(Opcode)) begin
                    nextState = ST_HALTED;
                end else if (Stop) begin
                    nextState = ST_PAUSE;
                end
            end

            ST_STEP: begin
                CoreEn    = 1'b1;
                nextState = isHalt(Opcode) ? ST_HALTED : ST_PAUSE;
            end

            ST_HALTED: begin
                loadEn    = 1'b1;
                addrClear = 1'b1;
                Done      = 1'b1;
                if (wordAccept) begin
                    nextState = loadDone ? ST_PRIME : ST_LOAD;
                end else if (Stop) begin
                    nextState = ST_IDLE;
                end else if (Run) begin
                    nextState = ST_PRIME;
                end
            end

            default: begin
                nextState = ST_IDLE;
                CoreRst   = 1'b1;
            end
        endcase
    end

    assign Status = state;

    // Cycle counter: cleared while priming, then counts every edge on which
    // the core was enabled, saturating at all-ones. The watchdog edge is not
    // counted, so a tripped run reports exactly WDOG_LIMIT cycles.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            CycleCount <= '0;
        end else if (state == ST_PRIME) begin
            CycleCount <= '0;
        end else if (CoreEn && !wdogHit && (CycleCount != '1)) begin
            CycleCount <= CycleCount + 1'b1;
        end
    end

endmodule
